// File: rtl/tilexy_cl_resp_if.sv
// tilexy_cl_resp_if: request, memory-write and completion channels of the cache-line responder
interface tilexy_cl_resp_if;
  logic         req_valid;
  logic         req_ready;
  logic [527:0] req_data;
  logic [46:0]  req_addr;
  logic [11:0]  req_size;
  logic         req_expun;
  logic [9:0]   req_src;
  logic         mem_we;
  logic [36:0]  mem_addr;
  logic [527:0] mem_wdata;
  logic [11:0]  mem_size;
  logic         mem_ack;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [9:0]   rsp_dst;
  logic [36:0]  rsp_addr;
  logic [1:0]   rsp_status;
  modport slave (
    input  req_valid, req_data, req_addr, req_size, req_expun, req_src, mem_ack, rsp_ready,
    output req_ready, mem_we, mem_addr, mem_wdata, mem_size, rsp_valid, rsp_dst, rsp_addr, rsp_status
  );
  modport master (
    output req_valid, req_data, req_addr, req_size, req_expun, req_src, mem_ack, rsp_ready,
    input  req_ready, mem_we, mem_addr, mem_wdata, mem_size, rsp_valid, rsp_dst, rsp_addr, rsp_status
  );
endinterface

// File: rtl/tilexy_cl_resp.sv
// tilexy_cl_resp: buffers mesh write requests, commits lines to local memory, returns completions; TILEXY_CL_RESP_TMO_EN adds a memory-ack timeout
module tilexy_cl_resp #(
  parameter int tile_X = 0,
  parameter int tile_Y = 0,
  parameter int DEPTH  = 4,
  parameter int TMO    = 255
) (
  input  logic clk,
  input  logic rst_n,
  tilexy_cl_resp_if.slave bus,
  output logic busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [9:0] TILE = {5'(tile_Y), 5'(tile_X)};
  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
  typedef struct packed {
    logic [527:0] data;
    logic [46:0]  addr;
    logic [11:0]  size;
    logic         expun;
    logic [9:0]   src;
  } entry_t;
  entry_t        buf_q [DEPTH];
  entry_t        head;
  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          mem_we_q, mem_we_d, rsp_valid_q, rsp_valid_d;
  logic [36:0]   mem_addr_q, mem_addr_d, rsp_addr_q, rsp_addr_d;
  logic [527:0]  mem_wdata_q, mem_wdata_d;
  logic [11:0]   mem_size_q, mem_size_d;
  logic [9:0]    rsp_dst_q, rsp_dst_d;
  logic [1:0]    rsp_status_q, rsp_status_d;
  logic          push, pop, skip, misroute, tmo_hit;

  assign head         = buf_q[rptr_q];
  assign misroute     = head.addr[46:37] != TILE;
  assign skip         = head.expun || misroute;
  assign bus.req_ready = count_q != (AW+1)'(DEPTH);
  assign push         = bus.req_valid && bus.req_ready;
  assign pop          = state_q == IDLE && count_q != '0;
  assign busy         = count_q != '0 || state_q != IDLE;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_size   = mem_size_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_dst    = rsp_dst_q;
  assign bus.rsp_addr   = rsp_addr_q;
  assign bus.rsp_status = rsp_status_q;

`ifdef TILEXY_CL_RESP_TMO_EN
  logic [7:0] wcnt_q, wcnt_d;
  assign wcnt_d  = state_q != WRITE ? '0 : wcnt_q + 8'(!bus.mem_ack);
  assign tmo_hit = !bus.mem_ack && wcnt_q == 8'(TMO - 1);
  // wait counter: zero outside WRITE, counts ack-less cycles inside it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt_q <= '0;
    else wcnt_q <= wcnt_d;
`else
  assign tmo_hit = 1'b0;
`endif

  // buffer bookkeeping: pointers wrap modulo DEPTH, count tracks occupancy
  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // FSM next state and next registered outputs; a popped request loads both channels' fields
  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_size_d   = mem_size_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dst_d    = rsp_dst_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_status_d = rsp_status_q;
    if (pop) begin
      state_d      = skip ? RESP : WRITE;
      mem_we_d     = !skip;
      rsp_valid_d  = skip;
      mem_addr_d   = head.addr[36:0];
      mem_wdata_d  = head.data;
      mem_size_d   = head.size;
      rsp_dst_d    = head.src;
      rsp_addr_d   = head.addr[36:0];
      rsp_status_d = misroute ? 2'b11 : head.expun ? 2'b01 : 2'b00;
    end else if (state_q == WRITE && (bus.mem_ack || tmo_hit)) begin
      state_d      = RESP;
      mem_we_d     = 1'b0;
      rsp_valid_d  = 1'b1;
      rsp_status_d = bus.mem_ack ? 2'b00 : 2'b10;
    end else if (state_q == RESP && bus.rsp_ready) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
    end
  end

  // request storage needs no reset: count gates every read
  always_ff @(posedge clk)
    if (push) buf_q[wptr_q] <= '{bus.req_data, bus.req_addr, bus.req_size, bus.req_expun, bus.req_src};

  // control state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_size_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dst_q    <= '0;
      rsp_addr_q   <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_size_q   <= mem_size_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dst_q    <= rsp_dst_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_status_q <= rsp_status_d;
    end
endmodule
